m2_4x4_approx: RTL and testbench

- Registered 4x4 unsigned approximate multiplier, variant M2 of the low-power approximate recursive multiplier family.
- Splits each operand into 2-bit halves and forms four 2x2 sub-products.
- The three lower-significance sub-products use the approximate 2x2 cell; the most-significant sub-product is exact.
- Used as the 4x4 building block for larger recursive multipliers and for accuracy/power characterisation.

---
 rtl/m2_4x4_approx.sv | 104 ++++++++++
 tb/tb_m2_4x4_approx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/m2_4x4_approx.sv
// -----------------------------------------------------------------------------
// m2_4x4_approx
//
// Registered 4x4 unsigned approximate multiplier, variant M2 of the low-power
// approximate recursive multiplier family.
//
// Each operand is split into 2-bit halves, giving four 2x2 sub-products:
//   LL = approx(aL, bL)   weight 1
//   HL = approx(aH, bL)   weight 4
//   LH = approx(aL, bH)   weight 4
//   HH = aH * bH (exact)  weight 16
// The approximate 2x2 cell is exact except that 3x3 gives 7 instead of 9.
// This keeps its output to 3 bits. The most-significant term stays exact
// because an error there would carry a weight of 32.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   in_valid    in   1  a/b are valid this cycle
//   a           in   4  unsigned multiplicand
//   b           in   4  unsigned multiplier
//   Y           out  8  registered approximate product
//   out_valid   out  1  Y holds the result of the previous edge's operands
//   approx_hit  out  1  (only with M2_ERR_FLAG_EN) Y differs from exact a*b
//
// Optional feature macro: M2_ERR_FLAG_EN adds the registered approx_hit flag.
//
// Handshake: the interface is valid-only, with no ready and no backpressure.
// The block accepts an operand pair on every rising edge where in_valid is 1.
// One edge later, out_valid is 1 and Y holds that pair's result.
// On an edge with in_valid=0, out_valid drops to 0 and Y (and approx_hit)
// keep their previous values.
// -----------------------------------------------------------------------------
module m2_4x4_approx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
`ifdef M2_ERR_FLAG_EN
  output logic       approx_hit,
`endif
  output logic [7:0] Y,
  output logic       out_valid
);

  // Approximate 2x2 cell: 3x3 collapses to 3'b111. Every other product fits in 3 bits.
  function automatic logic [2:0] approx_2x2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] p;
    p = {2'b00, x} * {2'b00, y};
    if (x == 2'd3 && y == 2'd3) approx_2x2 = 3'b111;
    else                        approx_2x2 = p[2:0];
  endfunction

  logic [1:0] a_l, a_h, b_l, b_h;
  logic [2:0] ll, hl, lh;
  logic [3:0] hh;
  logic [7:0] y_next;
  logic       hit_next;

  always_comb begin
    a_l = a[1:0];
    a_h = a[3:2];
    b_l = b[1:0];
    b_h = b[3:2];

    ll = approx_2x2(a_l, b_l);
    hl = approx_2x2(a_h, b_l);
    lh = approx_2x2(a_l, b_h);
    hh = {2'b00, a_h} * {2'b00, b_h};

    // The sum peaks at 207, so 8 bits never wrap.
    y_next = {hh, 4'b0000}
           + {3'b000, ({1'b0, hl} + {1'b0, lh}), 2'b00}
           + {5'b00000, ll};

    // The result is inexact exactly when one of the approximate cells saw 3x3.
    hit_next = (a_l == 2'd3 && b_l == 2'd3) ||
               (a_h == 2'd3 && b_l == 2'd3) ||
               (a_l == 2'd3 && b_h == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y         <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Y <= y_next;
    end
  end

`ifdef M2_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        approx_hit <= 1'b0;
    else if (in_valid) approx_hit <= hit_next;
  end
`else
  // The flag is not built in this configuration.
  logic unused_hit;
  assign unused_hit = hit_next;
`endif

endmodule

// File: tb/tb_m2_4x4_approx.sv
// -----------------------------------------------------------------------------
// tb_m2_4x4_approx
//
// Self-checking bench for m2_4x4_approx. The reference model takes the exact
// product a*b and subtracts the known error of each approximate 2x2 cell that
// sees 3x3. That error is 2 for LL and 2*4 for each of HL and LH.
// -----------------------------------------------------------------------------
module tb_m2_4x4_approx;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] Y;
  logic       out_valid;
`ifdef M2_ERR_FLAG_EN
  logic       approx_hit;
`endif

  m2_4x4_approx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef M2_ERR_FLAG_EN
    .approx_hit(approx_hit),
`endif
    .Y         (Y),
    .out_valid (out_valid)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_y;     // model of the held output value
  logic       last_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = int'(x) * int'(y);
    if (x[1:0] == 2'd3 && y[1:0] == 2'd3) p -= 2;
    if (x[3:2] == 2'd3 && y[1:0] == 2'd3) p -= 8;
    if (x[1:0] == 2'd3 && y[3:2] == 2'd3) p -= 8;
    return 8'(p);
  endfunction

  // ---------------------------------------------------------------- driver
  // Drives one cycle of stimulus, then checks the outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] ta, input logic [3:0] tb_);
    logic [7:0] e;
    in_valid = v;
    a        = ta;
    b        = tb_;
    if (v) exp_q.push_back(model(ta, tb_));
    @(posedge clk);
    #1;
    if (v) begin
      e        = exp_q.pop_front();
      last_y   = e;
      last_hit = (32'(e) != 32'(ta) * 32'(tb_));
    end
    check({tag, ".Y"}, 32'(Y), 32'(last_y));
    check({tag, ".vld"}, 32'(out_valid), 32'(v));
`ifdef M2_ERR_FLAG_EN
    check({tag, ".hit"}, 32'(approx_hit), 32'(last_hit));
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".Y"}, 32'(Y), 32'd0);
    check({tag, ".vld"}, 32'(out_valid), 32'd0);
`ifdef M2_ERR_FLAG_EN
    check({tag, ".hit"}, 32'(approx_hit), 32'd0);
`endif
    last_y   = 8'd0;
    last_hit = 1'b0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  int exact_cnt;

  initial begin
    in_valid = 1'b1;
    a        = 4'd5;
    b        = 4'd7;
    last_y   = 8'd0;
    last_hit = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;

    // Hold reset with valid operands present for several edges.
    repeat (4) @(posedge clk);
    #1;
    check_cleared("reset_hold");
    #2 rst_n = 1'b1;

    // Exact cases.
    step("exact_5x7",  1'b1, 4'd5, 4'd7);
    check("exact_5x7.val", 32'(Y), 32'd35);
    step("exact_2x3",  1'b1, 4'd2, 4'd3);
    check("exact_2x3.val", 32'(Y), 32'd6);
    step("exact_0x15", 1'b1, 4'd0, 4'd15);
    check("exact_0x15.val", 32'(Y), 32'd0);

    // Approximate cases, with absolute values from hand calculation.
    step("apx_3x3",   1'b1, 4'd3,  4'd3);
    check("apx_3x3.val", 32'(Y), 32'd7);
    step("apx_12x3",  1'b1, 4'd12, 4'd3);
    check("apx_12x3.val", 32'(Y), 32'd28);
    step("apx_15x15", 1'b1, 4'd15, 4'd15);
    check("apx_15x15.val", 32'(Y), 32'd207);
    step("apx_3x12",  1'b1, 4'd3,  4'd12);
    check("apx_3x12.val", 32'(Y), 32'd28);

    // Asynchronous reset asserted between edges clears the outputs at once.
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst");
    #1 rst_n = 1'b1;

    // Valid gaps: the output holds while the operands keep changing.
    step("gap_load", 1'b1, 4'd5, 4'd7);
    for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 4'd15, 4'd15);
    check("gap_hold.val", 32'(Y), 32'd35);

    // Exhaustive sweep, streamed back to back.
    exact_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step("sweep", 1'b1, 4'(i >> 4), 4'(i & 15));
      check("sweep.le_exact", 32'(Y <= 8'((i >> 4) * (i & 15))), 32'd1);
      if (32'(Y) == 32'((i >> 4) * (i & 15))) exact_cnt++;
    end
    check("sweep.exact_count", 32'(exact_cnt), 32'd216);

    // Mid-stream reset: the in-flight 15x15 is discarded.
    step("mid_pre", 1'b1, 4'd15, 4'd15);
    in_valid = 1'b1;
    a        = 4'd15;
    b        = 4'd15;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 check_cleared("mid_rst");
    #1 rst_n = 1'b1;
    step("mid_after", 1'b1, 4'd6, 4'd6);
    check("mid_after.val", 32'(Y), 32'd36);

    // Random traffic with random valid gaps.
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
